// File: rtl/pbuf2ddr_pkg.sv
// Shared widths, helpers and types for the pbuf-to-DDR readback path.
package pbuf2ddr_pkg;

  localparam int unsigned DDR_W  = 64;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BATCH  = 4;

  // Bits needed to index n items; never less than one.
  function automatic int unsigned bw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} pbuf2ddr_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] bank;
  } rd_tag_t;

endpackage

// File: rtl/pbuf2ddr_fifo.sv
// Synchronous FIFO with occupancy count; push into a full FIFO is allowed only alongside a pop.
module pbuf2ddr_fifo import pbuf2ddr_pkg::*; #(
  parameter int unsigned WIDTH = DDR_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [bw(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = bw(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic             full, do_push, do_pop;

  function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (32'(count) == DEPTH);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= inc_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= inc_ptr(rd_ptr_q);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pbuf2ddr.sv
// Streams the four pbuf banks to the DDR write channel, address-major / bank-minor.
// Define PBUF2DDR_CLEAR_EN to zero every word as it is read out.
module pbuf2ddr import pbuf2ddr_pkg::*; #(
  parameter int unsigned BUF_DEPTH  = 256,
  parameter int unsigned ADDR_W     = bw(BUF_DEPTH),
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         done,
  input  logic [7:0]                   conf_trans_num,
  input  logic [3:0]                   conf_bank_mask,
  output logic [3:0][ADDR_W-1:0]       pbuf_rd_addr,
  output logic [3:0]                   pbuf_rd_en,
  input  logic [3:0][DDR_W-1:0]        pbuf_rd_data,
  output logic [DDR_W-1:0]             ddr_data,
  output logic                         ddr_valid,
  input  logic                         ddr_ready
`ifdef PBUF2DDR_CLEAR_EN
  ,
  output logic [3:0][ADDR_W-1:0]       pbuf_wr_addr,
  output logic [3:0][DDR_W-1:0]        pbuf_wr_data,
  output logic [3:0]                   pbuf_wr_en
`endif
);

  localparam int unsigned CntW = bw(FIFO_DEPTH + 1);

  pbuf2ddr_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_cnt_q;
  logic [1:0]        bank_cnt_q;
  logic [7:0]        trans_num_q;
  logic [3:0]        mask_q;
  rd_tag_t           pipe_q [RD_LAT];
  logic [CntW-1:0]   fifo_count;
  logic              fifo_empty, credit, slot_go, rd_fire, last_slot;
  int unsigned       inflight;

  // Credit counts reads still in the pipe so the FIFO can never overflow.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + 32'(pipe_q[i].valid);
    credit    = (32'(fifo_count) + inflight) < FIFO_DEPTH;
    last_slot = (bank_cnt_q == 2'd3) && (32'(addr_cnt_q) == 32'(trans_num_q));
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StIssue;
      StIssue: if (credit && last_slot) state_d = StDrain;
      StDrain: if (inflight == 0 && fifo_empty) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    done       = (state_q == StIdle);
    slot_go    = (state_q == StIssue) && credit;
    rd_fire    = slot_go && mask_q[bank_cnt_q];
    pbuf_rd_en = '0;
    if (rd_fire) pbuf_rd_en[bank_cnt_q] = 1'b1;
    for (int b = 0; b < 4; b++) pbuf_rd_addr[b] = addr_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt_q  <= '0;
      bank_cnt_q  <= '0;
      trans_num_q <= '0;
      mask_q      <= '0;
    end else if (state_q == StIdle && start) begin
      addr_cnt_q  <= '0;
      bank_cnt_q  <= '0;
      trans_num_q <= conf_trans_num;
      mask_q      <= conf_bank_mask;
    end else if (slot_go) begin
      bank_cnt_q <= bank_cnt_q + 2'd1;
      if (bank_cnt_q == 2'd3) addr_cnt_q <= addr_cnt_q + 1'b1;
    end
  end

  // Tag pipe mirrors the pbuf read latency; clearing it on reset drops stale returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{valid: rd_fire, bank: bank_cnt_q};
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  pbuf2ddr_fifo #(
    .WIDTH (DDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_q[RD_LAT-1].valid),
    .push_data (pbuf_rd_data[pipe_q[RD_LAT-1].bank]),
    .pop       (ddr_valid && ddr_ready),
    .pop_data  (ddr_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign ddr_valid = !fifo_empty;

`ifdef PBUF2DDR_CLEAR_EN
  always_comb begin
    pbuf_wr_en   = pbuf_rd_en;
    pbuf_wr_addr = pbuf_rd_addr;
    pbuf_wr_data = '0;
  end
`endif

endmodule

// File: tb/tb_pbuf2ddr.sv
// Randomised directed bench for pbuf2ddr against a queue-based reference of the expected stream.
module tb_pbuf2ddr;
  import pbuf2ddr_pkg::*;

  localparam int unsigned BUF_DEPTH = 256;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned RD_LAT    = 2;

  logic clk = 1'b0;
  logic rst, start, done, ddr_valid, ddr_ready;
  logic [7:0] conf_trans_num;
  logic [3:0] conf_bank_mask, pbuf_rd_en;
  logic [3:0][ADDR_W-1:0] pbuf_rd_addr;
  logic [3:0][DDR_W-1:0]  pbuf_rd_data;
  logic [DDR_W-1:0]       ddr_data;
`ifdef PBUF2DDR_CLEAR_EN
  logic [3:0][ADDR_W-1:0] pbuf_wr_addr;
  logic [3:0][DDR_W-1:0]  pbuf_wr_data;
  logic [3:0]             pbuf_wr_en;
`endif

  pbuf2ddr #(
    .BUF_DEPTH  (BUF_DEPTH),
    .ADDR_W     (ADDR_W),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .done           (done),
    .conf_trans_num (conf_trans_num),
    .conf_bank_mask (conf_bank_mask),
    .pbuf_rd_addr   (pbuf_rd_addr),
    .pbuf_rd_en     (pbuf_rd_en),
    .pbuf_rd_data   (pbuf_rd_data),
    .ddr_data       (ddr_data),
    .ddr_valid      (ddr_valid),
    .ddr_ready      (ddr_ready)
`ifdef PBUF2DDR_CLEAR_EN
    ,
    .pbuf_wr_addr   (pbuf_wr_addr),
    .pbuf_wr_data   (pbuf_wr_data),
    .pbuf_wr_en     (pbuf_wr_en)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural pbuf: data appears RD_LAT cycles after rd_en, garbage otherwise.
  logic [DDR_W-1:0] mem [4][BUF_DEPTH];
  logic [DDR_W-1:0] rd_pipe [4][RD_LAT];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      rd_pipe[b][0] <= pbuf_rd_en[b] ? mem[b][pbuf_rd_addr[b]] : {$urandom, $urandom};
      for (int k = 1; k < RD_LAT; k++) rd_pipe[b][k] <= rd_pipe[b][k-1];
`ifdef PBUF2DDR_CLEAR_EN
      if (pbuf_wr_en[b]) mem[b][pbuf_wr_addr[b]] <= pbuf_wr_data[b];
`endif
    end
  end

  always_comb begin
    for (int b = 0; b < 4; b++) pbuf_rd_data[b] = rd_pipe[b][RD_LAT-1];
  end

  int errors = 0;
  int checks = 0;
  logic [DDR_W-1:0] exp_q [$];
  logic [DDR_W-1:0] held;
  logic [3:0] cur_mask;
  logic stall_prev, done_seen;
  int cycle, first_cyc, last_cyc, done_cyc, beats, valid_cycles, ready_pct, busy_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input bit rnd);
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < int'(BUF_DEPTH); a++)
        mem[b][a] <= rnd ? {$urandom, $urandom} : {32'(a), 32'(b)};
    @(negedge clk);
  endtask

  // One clock of monitoring: the beat sampled here transfers at the next rising edge.
  task automatic run_cycle();
    @(negedge clk);
    start = 1'b0;
    if (busy_cyc != 0 && cycle + 1 == busy_cyc) begin
      start          = 1'b1;
      conf_bank_mask = 4'hF;
      conf_trans_num = 8'd0;
    end
    ddr_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
    #1;
    cycle++;
    if (pbuf_rd_en != 4'b0) begin
      chk("rd_en_mask", 64'(pbuf_rd_en & ~cur_mask), 64'd0);
      chk("rd_en_onehot", 64'($onehot0(pbuf_rd_en)), 64'd1);
    end
    if (stall_prev) begin
      chk("stall_valid", 64'(ddr_valid), 64'd1);
      chk("stall_data", ddr_data, held);
    end
    if (ddr_valid) begin
      valid_cycles++;
      if (first_cyc < 0) first_cyc = cycle;
    end
    if (ddr_valid && ddr_ready) begin
      if (exp_q.size() == 0) chk("extra_beat", 64'd1, 64'd0);
      else chk("beat_data", ddr_data, exp_q.pop_front());
      beats++;
      last_cyc = cycle;
    end
    stall_prev = ddr_valid && !ddr_ready;
    held       = ddr_data;
    if (done && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cycle;
    end
  endtask

  task automatic run_xfer(input logic [3:0] mask, input int tn, input int pct, input int busy);
    int exp_beats;
    exp_q.delete();
    for (int a = 0; a <= tn; a++)
      for (int b = 0; b < 4; b++)
        if (mask[b]) exp_q.push_back(mem[b][a]);
    exp_beats    = exp_q.size();
    cur_mask     = mask;
    ready_pct    = pct;
    busy_cyc     = busy;
    cycle        = 0;
    first_cyc    = -1;
    last_cyc     = -1;
    done_cyc     = -1;
    beats        = 0;
    valid_cycles = 0;
    stall_prev   = 1'b0;
    done_seen    = 1'b0;
    @(negedge clk);
    conf_bank_mask = mask;
    conf_trans_num = 8'(tn);
    start          = 1'b1;
    ddr_ready      = 1'b1;
    while (!done_seen && cycle < 20000) run_cycle();
    chk("xfer_done_seen", 64'(done_seen), 64'd1);
    chk("beats_left", 64'(exp_q.size()), 64'd0);
    chk("beat_count", 64'(beats), 64'(exp_beats));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; ddr_ready = 1'b0;
    conf_trans_num = '0; conf_bank_mask = '0; cur_mask = '0;
    preload(1'b0);
    repeat (3) @(negedge clk);
    chk("rst_done", 64'(done), 64'd1);
    chk("rst_valid", 64'(ddr_valid), 64'd0);
    chk("rst_rd_en", 64'(pbuf_rd_en), 64'd0);
    chk("rst_rd_addr", 64'(pbuf_rd_addr), 64'd0);
    rst = 1'b0;

    // Full mask, four addresses, no backpressure.
    run_xfer(4'hF, 3, 100, 0);
    chk("t1_first_latency", 64'(first_cyc), 64'(RD_LAT + 2));
    chk("t1_back_to_back", 64'(last_cyc), 64'(first_cyc + 15));
    chk("t1_done_after_last", 64'(done_cyc > last_cyc), 64'd1);

    // Sparse mask.
    run_xfer(4'b0101, 7, 100, 0);

    // Random data, 30% ready, whole buffer.
    preload(1'b1);
    run_xfer(4'hF, 255, 30, 0);

    // Empty mask with a start pulse while busy.
    run_xfer(4'h0, 5, 100, 5);
    chk("t4_no_valid", 64'(valid_cycles), 64'd0);
    chk("t4_done_timing", 64'(done_cyc >= 24 && done_cyc <= 26), 64'd1);

    // Reset with reads in flight, then a clean transfer.
    cur_mask = 4'hF;
    @(negedge clk);
    conf_bank_mask = 4'hF; conf_trans_num = 8'd255; start = 1'b1; ddr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_done", 64'(done), 64'd1);
    chk("midrst_valid", 64'(ddr_valid), 64'd0);
    chk("midrst_rd_en", 64'(pbuf_rd_en), 64'd0);
    rst = 1'b0;
    run_xfer(4'hF, 3, 100, 0);
    chk("t5_first_latency", 64'(first_cyc), 64'(RD_LAT + 2));

`ifdef PBUF2DDR_CLEAR_EN
    preload(1'b0);
    run_xfer(4'hF, 1, 100, 0);
    repeat (2) @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      for (int a = 0; a < 2; a++) chk("clear_zero", mem[b][a], 64'd0);
      chk("clear_untouched", mem[b][2], {32'd2, 32'(b)});
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
